pipelined_prefix_adder: RTL

- Parametrised successor to the combinational PG generator. Generates bitwise propagate/generate (G = A&B, P = A^B), resolves carries with a Kogge-Stone parallel-prefix tree, and forms sum, carry-out and signed overflow.
- Three-stage registered pipeline with a valid/ready handshake and add/subtract mode.
- Serves as the datapath adder of the calculator ALU.

---
 rtl/pipelined_prefix_adder_if.sv | 37 +++
 rtl/pipelined_prefix_adder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_prefix_adder_if.sv
// pipelined_prefix_adder_if
// Carries the operand-side and result-side handshakes of the pipelined
// prefix adder.
//   master : the operand source and result consumer (drives operands, out_ready)
//   slave  : the adder itself (drives in_ready and the result)
// Signals:
//   in_valid/in_ready    operand handshake
//   A, B                 operands, N bits
//   op                   0 = add, 1 = subtract
//   cin                  carry-in, used in add mode only
//   out_valid/out_ready  result handshake
//   S, cout, ovf         sum/difference, carry out of the top bit, signed overflow
interface pipelined_prefix_adder_if #(
  parameter int N = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         op;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] S;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, A, B, op, cin, out_ready,
    input  in_ready, out_valid, S, cout, ovf
  );

  modport slave (
    input  in_valid, A, B, op, cin, out_ready,
    output in_ready, out_valid, S, cout, ovf
  );
endinterface

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder
// Three-stage Kogge-Stone adder/subtractor with a valid/ready handshake.
//   stage 1: bitwise propagate/generate of A and the (possibly inverted) B
//   stage 2: parallel-prefix carry tree, all levels combinational
//   stage 3: sum, carry-out and signed overflow
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pipelined_prefix_adder_if.slave (operands, op, cin, result, handshakes)
// Optional build macro PREFIX_ADDER_SAT_EN: saturate the signed result when
// ovf = 1 (ovf and cout still reported unchanged). Undefined: S wraps mod 2^N.
module pipelined_prefix_adder #(
  parameter int N = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  pipelined_prefix_adder_if.slave         bus
);

  localparam int LEVELS = $clog2(N);

  logic         adv;
  logic [N-1:0] b_eff;

  logic         v1_q, v1_d;
  logic [N-1:0] g1_q, g1_d;
  logic [N-1:0] p1_q, p1_d;
  logic         c01_q, c01_d;

  logic         v2_q, v2_d;
  logic [N-1:0] c2_q, c2_d;
  logic [N-1:0] p2_q, p2_d;
  logic         c02_q, c02_d;

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] s_q, s_d;
  logic         cout_q, cout_d;
  logic         ovf_q, ovf_d;

  logic [N-1:0] g_tree, p_tree, g_next, p_next;
  logic [N-1:0] sum_w;
  logic         ovf_w;

`ifdef PREFIX_ADDER_SAT_EN
  logic         a_sign1_q, a_sign1_d;
  logic         a_sign2_q, a_sign2_d;
`endif

  // Advance is global: a stalled result freezes every stage, bubbles included.
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.S        = s_q;
  assign bus.cout     = cout_q;
  assign bus.ovf      = ovf_q;

  assign b_eff = bus.op ? ~bus.B : bus.B;

  always_comb begin
    v1_d  = v1_q;
    g1_d  = g1_q;
    p1_d  = p1_q;
    c01_d = c01_q;
`ifdef PREFIX_ADDER_SAT_EN
    a_sign1_d = a_sign1_q;
`endif
    if (adv) begin
      v1_d  = bus.in_valid && adv;
      g1_d  = bus.A & b_eff;
      p1_d  = bus.A ^ b_eff;
      c01_d = bus.op ? 1'b1 : bus.cin;
`ifdef PREFIX_ADDER_SAT_EN
      a_sign1_d = bus.A[N-1];
`endif
    end
  end

  // Carry-in folds into bit 0's generate, so group G[i:0] is directly the
  // carry out of bit i. Each level reads only the previous level's values.
  always_comb begin
    g_tree    = g1_q;
    p_tree    = p1_q;
    g_tree[0] = g1_q[0] | (p1_q[0] & c01_q);
    g_next    = g_tree;
    p_next    = p_tree;
    for (int k = 0; k < LEVELS; k++) begin
      g_next = g_tree;
      p_next = p_tree;
      for (int i = (1 << k); i < N; i++) begin
        g_next[i] = g_tree[i] | (p_tree[i] & g_tree[i-(1<<k)]);
        p_next[i] = p_tree[i] & p_tree[i-(1<<k)];
      end
      g_tree = g_next;
      p_tree = p_next;
    end
  end

  always_comb begin
    v2_d  = v2_q;
    c2_d  = c2_q;
    p2_d  = p2_q;
    c02_d = c02_q;
`ifdef PREFIX_ADDER_SAT_EN
    a_sign2_d = a_sign2_q;
`endif
    if (adv) begin
      v2_d  = v1_q;
      c2_d  = g_tree;
      p2_d  = p1_q;
      c02_d = c01_q;
`ifdef PREFIX_ADDER_SAT_EN
      a_sign2_d = a_sign1_q;
`endif
    end
  end

  assign sum_w = p2_q ^ {c2_q[N-2:0], c02_q};
  assign ovf_w = c2_q[N-1] ^ c2_q[N-2];

  always_comb begin
    out_valid_d = out_valid_q;
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (adv) begin
      out_valid_d = v2_q;
      s_d         = sum_w;
      cout_d      = c2_q[N-1];
      ovf_d       = ovf_w;
`ifdef PREFIX_ADDER_SAT_EN
      if (ovf_w) begin
        s_d = a_sign2_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      g1_q        <= '0;
      p1_q        <= '0;
      c01_q       <= 1'b0;
      v2_q        <= 1'b0;
      c2_q        <= '0;
      p2_q        <= '0;
      c02_q       <= 1'b0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef PREFIX_ADDER_SAT_EN
      a_sign1_q   <= 1'b0;
      a_sign2_q   <= 1'b0;
`endif
    end else begin
      v1_q        <= v1_d;
      g1_q        <= g1_d;
      p1_q        <= p1_d;
      c01_q       <= c01_d;
      v2_q        <= v2_d;
      c2_q        <= c2_d;
      p2_q        <= p2_d;
      c02_q       <= c02_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
`ifdef PREFIX_ADDER_SAT_EN
      a_sign1_q   <= a_sign1_d;
      a_sign2_q   <= a_sign2_d;
`endif
    end
  end

endmodule
